brightness_ctrl: RTL and testbench
==================================

# brightness_ctrl

Front-panel brightness controller for the wall clock display. It turns two raw push-buttons (up/down) into an 8-bit duty-cycle percentage, 0..100. That value drives the `pwm_in` input of the display PWM stage directly downstream. The block synchronises and debounces both buttons, steps the level on each press, and auto-repeats while a button is held.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles needed to accept a button level change (5 ms at 100 MHz).
- `REPEAT_DELAY`, default 50000000: cycles from an accepted press to the first auto-repeat step (0.5 s).
- `REPEAT_PERIOD`, default 20000000: cycles between later auto-repeat steps (0.2 s).
- `STEP`, default 10: duty change per step, in percent (1..100).
- `RESET_DUTY`, default 50: duty after reset (0..100).

Ports:
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `btn_up` input, 1 bit: raw, asynchronous, active-high up button.
- `btn_down` input, 1 bit: raw, asynchronous, active-high down button.
- `duty` output, 8 bits: registered brightness percentage, always 0..100. Connects to PWM `pwm_in`.
- `duty_changed` output, 1 bit: one-cycle pulse in the same cycle `duty` takes a new value.
- `at_max` output, 1 bit: registered, high when `duty == 100`.
- `at_min` output, 1 bit: registered, high when `duty == 0`.

## Operation
- **Synchronisers.** Each button passes through a 2-flop synchroniser. The synchronised value is used from the second flop.
- **Debouncers.** Each button has its own debouncer: a stable level plus a counter.
  - The counter clears whenever the synced value equals the stable level.
  - Otherwise it increments. When it reaches `DEBOUNCE_CYCLES`, the stable level flips and the counter clears.
- **Step control FSM.** Input is `cmd`, derived from the stable levels: UP when only up is stable-high, DOWN when only down is stable-high, NONE otherwise (both high counts as NONE).
  - IDLE: on `cmd` becoming UP or DOWN, issue one step in that direction, load the repeat timer with `REPEAT_DELAY`, go to HOLD.
  - HOLD: the timer counts down. When it expires, issue a step, reload with `REPEAT_PERIOD`, stay in HOLD.
  - HOLD exit: if `cmd` becomes NONE, go to IDLE with no step.
  - HOLD direction change: if `cmd` switches UP↔DOWN directly, treat it as a fresh press (step in the new direction, reload `REPEAT_DELAY`).
- **Step arithmetic.** Use at least 9 bits internally. Saturate the result:
  - up: `min(duty + STEP, 100)`
  - down: `duty - STEP`, clamped at 0
- **`duty_changed` pulse.** Pulses only when the value actually changes. A step that leaves `duty` at 100 or 0 is silent, but the FSM still runs its repeat timing.
- **Flags.** `at_max` and `at_min` are updated in the same cycle as `duty`.

## Timing
- **Reset values.** While `reset` is asserted:
  - `duty = RESET_DUTY`, `duty_changed = 0`
  - `at_max` and `at_min` match `RESET_DUTY`
  - FSM in IDLE, all counters 0, synchronisers and stable levels 0
- **Reset mid-press.** If reset arrives mid-press, a button still held after reset deasserts gets a fresh debounce and then steps once.
- **Press latency.** A raw rising edge held at cycle 0 gives the new `duty` exactly `DEBOUNCE_CYCLES + 3` cycles later: 2 synchroniser cycles, `DEBOUNCE_CYCLES` counting cycles, 1 register stage.
- **Repeat timing.**
  - First repeat: exactly `REPEAT_DELAY` cycles after the first step.
  - Later repeats: every `REPEAT_PERIOD` cycles.
- **Glitches.** A raw glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `duty`.
- **Rate limit.** At most one step per cycle.
- **`duty` stability.** `duty` is held between steps, so the downstream PWM only ever sees a value in 0..100.

## Test plan
Use `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=20`, `REPEAT_PERIOD=8`, `STEP=10`, `RESET_DUTY=50`.
- **Reset.** Assert `reset` mid-stream → `duty=50`, `duty_changed=0`, `at_max=0`, `at_min=0` immediately, without waiting for a clock edge.
- **Single press.** Hold `btn_up` for 10 cycles, then release → `duty` becomes 60 exactly 7 cycles after the edge, with one `duty_changed` pulse; no further change.
- **Glitch reject.** 3-cycle pulses on `btn_down` → `duty` stays 50 and `duty_changed` never pulses.
- **Auto-repeat up.** Hold `btn_up` for 100 cycles → 60 at t=7, 70 at t=27, 80 at t=35, 90 at t=43, 100 at t=51 with `at_max=1`. Later repeats at t=59 and beyond give no pulse and `duty` stays 100.
- **Down to floor.** Reset, then hold `btn_down` → steps 40, 30, 20, 10, 0, with `at_min=1` at 0 and no underflow wrap.
- **Both buttons / direction swap.** Press up, then also press down → stepping stops and FSM goes to IDLE. Release up while down is held → an immediate down step, then repeats at `REPEAT_DELAY` / `REPEAT_PERIOD` spacing.

Source files
------------

// File: rtl/brightness_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : brightness_ctrl
// Purpose  : Front-panel brightness controller. Synchronises and debounces
//            the up/down push-buttons, steps an 8-bit duty percentage
//            (0..100) on each press and auto-repeats while a button is held.
// Revision : 1.0 - initial release
// ============================================================================
module brightness_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000,
  parameter int STEP            = 10,
  parameter int RESET_DUTY      = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [7:0] duty,
  output logic       duty_changed,
  output logic       at_max,
  output logic       at_min
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1: the flip happens
  // on the cycle that would have made it DEBOUNCE_CYCLES.
  localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_tmr_w   = $clog2(c_rep_max + 1);
  localparam logic [c_tmr_w-1:0] c_delay   = c_tmr_w'(REPEAT_DELAY);
  localparam logic [c_tmr_w-1:0] c_period  = c_tmr_w'(REPEAT_PERIOD);
  localparam logic [c_tmr_w-1:0] c_tmr_one = c_tmr_w'(1);

  localparam logic [8:0] c_step       = 9'(STEP);
  localparam logic [8:0] c_max9       = 9'd100;
  localparam logic [7:0] c_reset_duty = 8'(RESET_DUTY);
  localparam logic       c_rst_max    = (RESET_DUTY == 100);
  localparam logic       c_rst_min    = (RESET_DUTY == 0);

  // Bit 0 = up button, bit 1 = down button
  logic [1:0] w_raw;
  logic [1:0] w_stable;

  assign w_raw = {btn_down, btn_up};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic               r_s1;
    logic               r_s2;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;

    // Two-flop synchroniser for the raw asynchronous button
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
      end else begin
        r_s1 <= w_raw[gi];
        r_s2 <= r_s1;
      end
    end

    // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive mismatches
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_stable <= 1'b0;
        r_cnt    <= '0;
      end else if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_deb_last) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end

    assign w_stable[gi] = r_stable;
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_dir_up;
  logic [c_tmr_w-1:0] r_timer;
  logic [7:0]         r_duty;
  logic               r_changed;
  logic               r_at_max;
  logic               r_at_min;

  logic       w_cmd_up;
  logic       w_cmd_dn;
  logic       w_cmd_any;
  logic       w_fresh;
  logic       w_repeat;
  logic [8:0] w_up_sum;
  logic [8:0] w_dn_diff;
  logic [7:0] w_up_val;
  logic [7:0] w_dn_val;
  logic [7:0] w_next_duty;

  // Both buttons stable-high is treated as no command
  assign w_cmd_up  = w_stable[0] & ~w_stable[1];
  assign w_cmd_dn  = w_stable[1] & ~w_stable[0];
  assign w_cmd_any = w_cmd_up | w_cmd_dn;

  // Saturating step arithmetic and step decision for this cycle
  always_comb begin
    w_fresh   = 1'b0;
    w_repeat  = 1'b0;
    w_up_sum  = {1'b0, r_duty} + c_step;
    w_dn_diff = {1'b0, r_duty} - c_step;
    w_up_val  = (w_up_sum > c_max9) ? 8'd100 : w_up_sum[7:0];
    w_dn_val  = w_dn_diff[8] ? 8'd0 : w_dn_diff[7:0];
    case (r_state)
      ST_IDLE: w_fresh = w_cmd_any;
      ST_HOLD: begin
        if (w_cmd_any) begin
          if (w_cmd_up != r_dir_up) begin
            w_fresh = 1'b1;
          end else if (r_timer == c_tmr_one) begin
            w_repeat = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (w_fresh || w_repeat) begin
      w_next_duty = w_cmd_up ? w_up_val : w_dn_val;
    end else begin
      w_next_duty = r_duty;
    end
  end

  // Step-control FSM with registered duty, change pulse and limit flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_dir_up  <= 1'b0;
      r_timer   <= '0;
      r_duty    <= c_reset_duty;
      r_changed <= 1'b0;
      r_at_max  <= c_rst_max;
      r_at_min  <= c_rst_min;
    end else begin
      r_duty    <= w_next_duty;
      r_changed <= (w_next_duty != r_duty);
      r_at_max  <= (w_next_duty == 8'd100);
      r_at_min  <= (w_next_duty == 8'd0);
      case (r_state)
        ST_IDLE: begin
          if (w_fresh) begin
            r_state  <= ST_HOLD;
            r_dir_up <= w_cmd_up;
            r_timer  <= c_delay;
          end
        end
        ST_HOLD: begin
          if (!w_cmd_any) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
          end else if (w_fresh) begin
            r_dir_up <= w_cmd_up;
            r_timer  <= c_delay;
          end else if (w_repeat) begin
            r_timer <= c_period;
          end else begin
            r_timer <= r_timer - c_tmr_one;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign duty         = r_duty;
  assign duty_changed = r_changed;
  assign at_max       = r_at_max;
  assign at_min       = r_at_min;

endmodule
`default_nettype wire

// File: tb/tb_brightness_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_brightness_ctrl
// Purpose  : Self-checking bench for brightness_ctrl: behavioural model
//            compared every cycle, plus literal scenario expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_brightness_ctrl;

  localparam int D   = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int ST  = 10;
  localparam int RST = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [7:0] duty;
  logic       duty_changed;
  logic       at_max;
  logic       at_min;

  int n_tests = 0;
  int n_fail  = 0;

  int up_vals[5] = '{60, 70, 80, 90, 100};
  int dn_vals[5] = '{40, 30, 20, 10, 0};

  brightness_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .STEP           (ST),
    .RESET_DUTY     (RST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .duty        (duty),
    .duty_changed(duty_changed),
    .at_max      (at_max),
    .at_min      (at_min)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buttons: index 0 = up, 1 = down. Repeats are scheduled by absolute cycle.
  bit     m_s1[2];
  bit     m_s2[2];
  bit     m_stab[2];
  int     m_run[2];
  int     m_duty = RST;
  bit     m_chg;
  bit     m_active;
  bit     m_dir;
  longint m_due;
  longint m_cyc = 0;
  bit     cmd_up;
  bit     cmd_dn;

  function automatic int stepped(input int d, input bit up);
    int n;
    if (up) n = (d + ST > 100) ? 100 : d + ST;
    else    n = (d - ST < 0) ? 0 : d - ST;
    return n;
  endfunction

  always begin
    @(posedge clk);
    if (reset) begin
      m_duty = RST; m_chg = 0; m_active = 0; m_dir = 0; m_due = 0;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_stab[b] = 0; m_run[b] = 0;
      end
    end else begin
      cmd_up = m_stab[0] && !m_stab[1];
      cmd_dn = m_stab[1] && !m_stab[0];
      m_chg  = 0;
      if (!cmd_up && !cmd_dn) begin
        m_active = 0;
      end else if (!m_active || m_dir != cmd_up || m_cyc == m_due) begin
        int nd;
        nd = stepped(m_duty, cmd_up);
        m_chg = (nd != m_duty);
        m_duty = nd;
        m_due = m_cyc + ((m_active && m_dir == cmd_up) ? RP : RD);
        m_active = 1;
        m_dir = cmd_up;
      end
      for (int b = 0; b < 2; b++) begin
        if (m_s2[b] != m_stab[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_stab[b] = !m_stab[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
        m_s2[b] = m_s1[b];
      end
      m_s1[0] = btn_up;
      m_s1[1] = btn_down;
    end
    m_cyc++;
    #1;
    check("model_duty", int'(duty), m_duty);
    check("model_changed", int'(duty_changed), int'(m_chg));
    check("model_at_max", int'(at_max), int'(m_duty == 100));
    check("model_at_min", int'(at_min), int'(m_duty == 0));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_hold(input bit go_up, input int hold);
    int times[5] = '{7, 27, 35, 43, 51};
    if (go_up) btn_up = 1'b1;
    else       btn_down = 1'b1;
    for (int t = 1; t <= hold; t++) begin
      tick();
      if (t == 6) check("pre_first_step", int'(duty), 50);
      for (int k = 0; k < 5; k++) begin
        if (t == times[k]) begin
          check("repeat_duty", int'(duty), go_up ? up_vals[k] : dn_vals[k]);
          check("repeat_pulse", int'(duty_changed), 1);
        end
      end
      if (t == 51) check("limit_flag", int'(go_up ? at_max : at_min), 1);
      if (t == 59) begin
        check("sat_duty", int'(duty), go_up ? 100 : 0);
        check("sat_pulse", int'(duty_changed), 0);
      end
    end
    btn_up = 1'b0;
    btn_down = 1'b0;
  endtask

  initial begin
    int pulses;
    bit saw;

    // Reset state
    repeat (3) tick();
    check("reset_duty", int'(duty), 50);
    check("reset_changed", int'(duty_changed), 0);
    check("reset_at_max", int'(at_max), 0);
    check("reset_at_min", int'(at_min), 0);
    reset = 1'b0;

    // Single press: 10 cycles, one step after 7 cycles
    pulses = 0;
    btn_up = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 11) btn_up = 1'b0;
      if (duty_changed) pulses++;
      if (t == 6) check("single_pre", int'(duty), 50);
      if (t == 7) begin
        check("single_duty", int'(duty), 60);
        check("single_pulse", int'(duty_changed), 1);
      end
    end
    btn_up = 1'b0;
    check("single_pulse_count", pulses, 1);
    check("single_hold", int'(duty), 60);

    // Asynchronous reset mid-press, then fresh debounce while still held
    btn_up = 1'b1;
    repeat (12) tick();
    reset = 1'b1;
    #1;
    check("async_reset_duty", int'(duty), 50);
    check("async_reset_changed", int'(duty_changed), 0);
    check("async_reset_at_max", int'(at_max), 0);
    check("async_reset_at_min", int'(at_min), 0);
    tick();
    tick();
    reset = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 6) check("post_reset_pre", int'(duty), 50);
      if (t == 7) check("post_reset_step", int'(duty), 60);
    end
    btn_up = 1'b0;
    repeat (20) tick();

    // Glitch rejection
    reset_pulse();
    saw = 1'b0;
    for (int g = 0; g < 3; g++) begin
      btn_down = 1'b1;
      repeat (3) begin tick(); saw |= duty_changed; end
      btn_down = 1'b0;
      repeat (6) begin tick(); saw |= duty_changed; end
    end
    check("glitch_duty", int'(duty), 50);
    check("glitch_no_pulse", int'(saw), 0);

    // Auto-repeat up to the ceiling
    reset_pulse();
    run_hold(1'b1, 100);
    repeat (10) tick();

    // Down to the floor
    reset_pulse();
    run_hold(1'b0, 80);
    repeat (10) tick();

    // Both buttons, then swap direction
    reset_pulse();
    btn_up = 1'b1;
    repeat (15) tick();
    btn_down = 1'b1;
    repeat (30) tick();
    check("both_stop", int'(duty), 60);
    btn_up = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 7)  check("swap_first", int'(duty), 50);
      if (t == 27) check("swap_repeat1", int'(duty), 40);
      if (t == 35) check("swap_repeat2", int'(duty), 30);
    end
    btn_down = 1'b0;
    repeat (10) tick();

    // Randomised button activity with occasional resets
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset_pulse();
      end else begin
        btn_up   = 1'($urandom_range(0, 1));
        btn_down = 1'($urandom_range(0, 3) == 0);
        repeat ($urandom_range(1, 40)) tick();
      end
    end
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
